data_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port, synchronous-read data memory between the pipeline memory stage (CPU) and a secondary bus master (DMA/program loader). It sits between the memory-stage pipeline register and the data memory. It grants at most one access per cycle and stalls the CPU when the DMA owns the port. It routes one-cycle-latency read data back to whichever requester issued the read.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/arb_starve_counter.sv | 40 ++++
 rtl/data_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   ArbStates        : arbiter FSM state (CPU priority / one-cycle forced DMA slot)
//   ArbOwner         : which requester owns the read that is in flight
//   STARVE_CNT_WIDTH : width of the saturating DMA starve counter
package dmem_arb_pkg;

  typedef enum logic {
    ARB_CPU       = 1'b0,
    ARB_DMA_FORCE = 1'b1
  } ArbStates;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } ArbOwner;

  localparam int unsigned STARVE_CNT_WIDTH = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter
// Saturating count of consecutive cycles in which the DMA was denied.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : clear to zero (takes precedence over inc)
//   inc         : DMA denied this cycle; count up, saturating at all-ones
//   limit_next  : this increment brings the count up to LIMIT, so the
//                 following cycle must be a forced DMA slot
module arb_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic limit_next
);

  localparam logic [STARVE_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [STARVE_CNT_WIDTH:0]   LIMIT_W = LIMIT[STARVE_CNT_WIDTH:0];

  logic [STARVE_CNT_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  // Look one increment ahead so the forced slot lands on the cycle right
  // after the LIMIT-th denial instead of one cycle later.
  assign limit_next = inc && (({1'b0, count} + 1'b1) >= LIMIT_W);

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares the single-port, synchronous-read data memory between the CPU
// memory stage and a DMA/program-loader master. At most one access is granted
// per cycle; read data (one-cycle latency) is steered back to its issuer.
//
// Build option: DMEM_ARB_STARVE_EN
//   defined   : starve counter + one-cycle forced DMA slot after STARVE_LIMIT
//               consecutive denials (CPU stalls for that cycle)
//   undefined : strict CPU priority, oCpuStall tied to 0, STARVE_LIMIT unused
//
// Handshake: a CPU request is accepted in the cycle iCpuReq=1 and
// oCpuStall=0; a DMA request is accepted in the cycle iDmaReq=1 and
// oDmaGnt=1, and the DMA holds its request fields stable until then. Read
// returns are single-cycle pulses (no back-pressure): RValid is high the
// cycle after acceptance, with the data on RData.
//
// Ports:
//   iClk, iRst                          : clock, asynchronous active-low reset
//   iCpuReq/We/Addr/WData/ByteEn        : CPU access
//   oCpuStall, oCpuRData, oCpuRValid    : CPU stall and read return
//   iDmaReq/We/Addr/WData/ByteEn        : DMA access
//   oDmaGnt, oDmaRData, oDmaRValid      : DMA accept and read return
//   oMemEn/We/Addr/WData/ByteEn         : memory port, muxed from the winner
//   iMemRData                           : memory read data (cycle after read)
//   dbg_state                           : current arbiter FSM state
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iCpuReq,
  input  logic                    iCpuWe,
  input  logic [ADDR_WIDTH-1:0]   iCpuAddr,
  input  logic [DATA_WIDTH-1:0]   iCpuWData,
  input  logic [DATA_WIDTH/8-1:0] iCpuByteEn,
  output logic                    oCpuStall,
  output logic [DATA_WIDTH-1:0]   oCpuRData,
  output logic                    oCpuRValid,
  input  logic                    iDmaReq,
  input  logic                    iDmaWe,
  input  logic [ADDR_WIDTH-1:0]   iDmaAddr,
  input  logic [DATA_WIDTH-1:0]   iDmaWData,
  input  logic [DATA_WIDTH/8-1:0] iDmaByteEn,
  output logic                    oDmaGnt,
  output logic [DATA_WIDTH-1:0]   oDmaRData,
  output logic                    oDmaRValid,
  output logic                    oMemEn,
  output logic                    oMemWe,
  output logic [ADDR_WIDTH-1:0]   oMemAddr,
  output logic [DATA_WIDTH-1:0]   oMemWData,
  output logic [DATA_WIDTH/8-1:0] oMemByteEn,
  input  logic [DATA_WIDTH-1:0]   iMemRData,
  output ArbStates                dbg_state
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("data_mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic    cpu_gnt;
  logic    dma_gnt;
  ArbOwner owner_q;
  logic    rd_pend_q;

`ifdef DMEM_ARB_STARVE_EN
  ArbStates state_q;
  ArbStates state_d;
  logic     starve_inc;
  logic     starve_clr;
  logic     force_hit;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= ARB_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  // All grants are gated by iRst so nothing reaches the memory during reset.
  always_comb begin
    state_d    = ARB_CPU;
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    oCpuStall  = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    if (iRst) begin
      case (state_q)
        ARB_CPU: begin
          cpu_gnt    = iCpuReq;
          dma_gnt    = !iCpuReq && iDmaReq;
          starve_inc = iCpuReq && iDmaReq;
          starve_clr = !iDmaReq || dma_gnt;
          if (force_hit) begin
            state_d = ARB_DMA_FORCE;
          end
        end
        ARB_DMA_FORCE: begin
          // A withdrawn DMA request leaves this slot idle.
          dma_gnt    = iDmaReq;
          oCpuStall  = iCpuReq;
          starve_clr = 1'b1;
        end
        default: begin
          state_d = ARB_CPU;
        end
      endcase
    end
  end

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk        (iClk),
    .rst_n      (iRst),
    .clr        (starve_clr),
    .inc        (starve_inc),
    .limit_next (force_hit)
  );

  assign dbg_state = state_q;
`else
  assign cpu_gnt   = iRst && iCpuReq;
  assign dma_gnt   = iRst && !iCpuReq && iDmaReq;
  assign oCpuStall = 1'b0;
  assign dbg_state = ARB_CPU;
`endif

  assign oDmaGnt = dma_gnt;

  always_comb begin
    oMemEn     = cpu_gnt || dma_gnt;
    oMemWe     = 1'b0;
    oMemAddr   = '0;
    oMemWData  = '0;
    oMemByteEn = '0;
    if (cpu_gnt) begin
      oMemWe     = iCpuWe;
      oMemAddr   = iCpuAddr;
      oMemWData  = iCpuWData;
      oMemByteEn = iCpuByteEn;
    end else if (dma_gnt) begin
      oMemWe     = iDmaWe;
      oMemAddr   = iDmaAddr;
      oMemWData  = iDmaWData;
      oMemByteEn = iDmaByteEn;
    end
  end

  // Remember who issued the read in flight; the memory answers next cycle.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      owner_q   <= OWN_CPU;
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= oMemEn && !oMemWe;
      if (oMemEn) begin
        owner_q <= dma_gnt ? OWN_DMA : OWN_CPU;
      end
    end
  end

  assign oCpuRData  = iMemRData;
  assign oDmaRData  = iMemRData;
  assign oCpuRValid = rd_pend_q && (owner_q == OWN_CPU);
  assign oDmaRValid = rd_pend_q && (owner_q == OWN_DMA);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
// Self-checking bench for data_mem_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a behavioural model of the
// arbitration rules and a queue of expected read returns.
// Honours DMEM_ARB_STARVE_EN the same way as the design.
module tb_data_mem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  logic          iCpuReq, iCpuWe;
  logic [AW-1:0] iCpuAddr;
  logic [DW-1:0] iCpuWData;
  logic [BW-1:0] iCpuByteEn;
  logic          oCpuStall, oCpuRValid;
  logic [DW-1:0] oCpuRData;
  logic          iDmaReq, iDmaWe;
  logic [AW-1:0] iDmaAddr;
  logic [DW-1:0] iDmaWData;
  logic [BW-1:0] iDmaByteEn;
  logic          oDmaGnt, oDmaRValid;
  logic [DW-1:0] oDmaRData;
  logic          oMemEn, oMemWe;
  logic [AW-1:0] oMemAddr;
  logic [DW-1:0] oMemWData;
  logic [BW-1:0] oMemByteEn;
  logic [DW-1:0] iMemRData;
  ArbStates      dbg_state;

  data_mem_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iCpuReq    (iCpuReq),
    .iCpuWe     (iCpuWe),
    .iCpuAddr   (iCpuAddr),
    .iCpuWData  (iCpuWData),
    .iCpuByteEn (iCpuByteEn),
    .oCpuStall  (oCpuStall),
    .oCpuRData  (oCpuRData),
    .oCpuRValid (oCpuRValid),
    .iDmaReq    (iDmaReq),
    .iDmaWe     (iDmaWe),
    .iDmaAddr   (iDmaAddr),
    .iDmaWData  (iDmaWData),
    .iDmaByteEn (iDmaByteEn),
    .oDmaGnt    (oDmaGnt),
    .oDmaRData  (oDmaRData),
    .oDmaRValid (oDmaRValid),
    .oMemEn     (oMemEn),
    .oMemWe     (oMemWe),
    .oMemAddr   (oMemAddr),
    .oMemWData  (oMemWData),
    .oMemByteEn (oMemByteEn),
    .iMemRData  (iMemRData),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  // One entry per cycle: 2'b01 CPU read in flight, 2'b10 DMA read, 0 none.
  logic [1:0] exp_q[$];

  // Arbitration model: consecutive DMA denials and pending forced slot.
  int denied      = 0;
  bit force_now   = 1'b0;
  bit last_dma_ok = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_cpu(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    iCpuReq = req; iCpuWe = we; iCpuAddr = addr; iCpuWData = wdata; iCpuByteEn = be;
  endtask

  task automatic drive_dma(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    iDmaReq = req; iDmaWe = we; iDmaAddr = addr; iDmaWData = wdata; iDmaByteEn = be;
  endtask

  // Called at posedge+1 with requests already driven. Checks this cycle's
  // outputs against the model, then advances to the next posedge+1.
  task automatic run_cycle(input logic [DW-1:0] mem_rdata);
    logic          e_cpu, e_dma, e_stall, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_be;
    logic [1:0]    ret;
    iMemRData = mem_rdata;
    #1;
    if (force_now) begin
      e_cpu = 1'b0; e_dma = iDmaReq; e_stall = iCpuReq;
    end else begin
      e_cpu = iCpuReq; e_dma = !iCpuReq && iDmaReq; e_stall = 1'b0;
    end
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
    if (e_cpu) begin
      e_we = iCpuWe; e_addr = iCpuAddr; e_wdata = iCpuWData; e_be = iCpuByteEn;
    end else if (e_dma) begin
      e_we = iDmaWe; e_addr = iDmaAddr; e_wdata = iDmaWData; e_be = iDmaByteEn;
    end
    ret = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;

    check("mem_en",     64'(oMemEn),     64'(e_cpu || e_dma));
    check("mem_we",     64'(oMemWe),     64'(e_we));
    check("mem_addr",   64'(oMemAddr),   64'(e_addr));
    check("mem_wdata",  64'(oMemWData),  64'(e_wdata));
    check("mem_be",     64'(oMemByteEn), 64'(e_be));
    check("dma_gnt",    64'(oDmaGnt),    64'(e_dma));
    check("cpu_stall",  64'(oCpuStall),  64'(e_stall));
    check("state",      64'(dbg_state),  64'(force_now));
    check("cpu_rvalid", 64'(oCpuRValid), 64'(ret == 2'b01));
    check("dma_rvalid", 64'(oDmaRValid), 64'(ret == 2'b10));
    if (ret == 2'b01) check("cpu_rdata", 64'(oCpuRData), 64'(mem_rdata));
    if (ret == 2'b10) check("dma_rdata", 64'(oDmaRData), 64'(mem_rdata));

    exp_q.push_back((e_cpu && !iCpuWe) ? 2'b01 : (e_dma && !iDmaWe) ? 2'b10 : 2'b00);
    last_dma_ok = e_dma;

`ifdef DMEM_ARB_STARVE_EN
    if (force_now) begin
      force_now = 1'b0;
      denied    = 0;
    end else if (iCpuReq && iDmaReq) begin
      denied++;
      if (denied >= LIMIT) force_now = 1'b1;
    end else begin
      denied = 0;
    end
`endif

    @(posedge iClk);
    #1;
  endtask

  // Assert reset at posedge+1, check the quiet outputs, release two edges later.
  task automatic apply_reset();
    iRst = 1'b0;
    exp_q.delete();
    denied    = 0;
    force_now = 1'b0;
    #1;
    check("rst_mem_en",     64'(oMemEn),     64'(0));
    check("rst_dma_gnt",    64'(oDmaGnt),    64'(0));
    check("rst_cpu_rvalid", 64'(oCpuRValid), 64'(0));
    check("rst_dma_rvalid", 64'(oDmaRValid), 64'(0));
    check("rst_state",      64'(dbg_state),  64'(ARB_CPU));
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b1;
  endtask

  task automatic random_dma();
    drive_dma(($urandom_range(0, 99) < 50), 1'($urandom_range(0, 1)), $urandom,
              $urandom, 4'($urandom_range(0, 15)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    iRst = 1'b0;
    iMemRData = '0;
    drive_cpu(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    drive_dma(1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
    @(posedge iClk);
    #1;
    // Reset with both requesters active.
    apply_reset();
    drive_cpu(1'b0, 1'b0, '0, '0, '0);
    drive_dma(1'b0, 1'b0, '0, '0, '0);
    run_cycle($urandom);

    // CPU-only read of 0x10; the memory answers 0xDEADBEEF next cycle.
    drive_cpu(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    run_cycle($urandom);
    drive_cpu(1'b0, 1'b0, '0, '0, '0);
    run_cycle(32'hDEADBEEF);
    run_cycle($urandom);

    // Both requesting continuously for 20 cycles.
    drive_cpu(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    drive_dma(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      drive_cpu(1'b1, 1'($urandom_range(0, 1)), 32'h100 + 32'(i * 4), $urandom, 4'hF);
      if (last_dma_ok) drive_dma(1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'h0, 4'hF);
      run_cycle($urandom);
    end
    drive_cpu(1'b0, 1'b0, '0, '0, '0);
    drive_dma(1'b0, 1'b0, '0, '0, '0);
    run_cycle($urandom);

    // CPU read, DMA read, DMA write, DMA read on consecutive cycles.
    drive_cpu(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    run_cycle($urandom);
    drive_cpu(1'b0, 1'b0, '0, '0, '0);
    drive_dma(1'b1, 1'b0, 32'h24, 32'h0, 4'hF);
    run_cycle(32'h1111_2222);
    drive_dma(1'b1, 1'b1, 32'h28, 32'hCAFE_F00D, 4'h3);
    run_cycle(32'h3333_4444);
    drive_dma(1'b1, 1'b0, 32'h2C, 32'h0, 4'hF);
    run_cycle(32'h5555_6666);
    drive_dma(1'b0, 1'b0, '0, '0, '0);
    run_cycle(32'h7777_8888);
    run_cycle($urandom);

    // Reset the cycle after a granted CPU read: the return must vanish.
    drive_cpu(1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
    run_cycle($urandom);
    drive_cpu(1'b0, 1'b0, '0, '0, '0);
    apply_reset();
    repeat (3) run_cycle($urandom);

    // Random traffic; the DMA keeps its request until it is accepted.
    random_dma();
    for (int i = 0; i < 400; i++) begin
      drive_cpu(($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)), $urandom,
                $urandom, 4'($urandom_range(0, 15)));
      if (last_dma_ok || !iDmaReq) random_dma();
      run_cycle($urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
